// File: rtl/angle_range_reduce_if.sv
// ---------------------------------------------------------------------------
// angle_range_reduce_if
//   Bundles the three handshakes of the angle range reducer:
//     in_*   : angle source -> reducer (valid/ready, angle, mode)
//     out_*  : reducer -> trig datapath (valid/ready, angle, quadrant, error)
//     add_*  : reducer -> shared float adder (operands, start pulse, sum, ready)
//   Modports:
//     master : the surrounding system (angle source, consumer, adder)
//     slave  : the reducer itself
// ---------------------------------------------------------------------------
interface angle_range_reduce_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_angle;
  logic         in_mode;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_angle;
  logic [1:0]   out_quadrant;
  logic         out_error;

  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_start;
  logic [W-1:0] add_sum;
  logic         add_ready;

  modport master (
    output in_valid, in_angle, in_mode, out_ready, add_sum, add_ready,
    input  in_ready, out_valid, out_angle, out_quadrant, out_error,
           add_a, add_b, add_start
  );

  modport slave (
    input  in_valid, in_angle, in_mode, out_ready, add_sum, add_ready,
    output in_ready, out_valid, out_angle, out_quadrant, out_error,
           add_a, add_b, add_start
  );
endinterface

// File: rtl/angle_range_reduce.sv
// ---------------------------------------------------------------------------
// angle_range_reduce
//   Reduces one float angle (radians) to [0, 2pi) (mode 0) or [-pi, pi)
//   (mode 1), reporting the quadrant of the [0, 2pi) value and an error flag
//   for NaN/Inf inputs or when MAX_ITER reduction passes are not enough.
//   Every add/subtract is issued to an external shared float adder.
//
//   Ports:
//     clk   : clock, all logic on the rising edge
//     reset : asynchronous, active-low; clears all state
//     bus   : angle_range_reduce_if.slave
//             in_valid/in_ready/in_angle/in_mode    input angle handshake
//             out_valid/out_ready/out_angle/
//             out_quadrant/out_error                result handshake
//             add_a/add_b/add_start/add_sum/
//             add_ready                             external adder port
// ---------------------------------------------------------------------------
module angle_range_reduce #(
  parameter int                          EXP_LEN             = 8,
  parameter int                          MANTISSA_LEN        = 23,
  parameter logic [MANTISSA_LEN-1:0]     PI_MANTISSA         = 23'h490FDB,
  parameter logic [MANTISSA_LEN-1:0]     THREE_PI_2_MANTISSA = 23'h16CBE4,
  parameter int                          MAX_ITER            = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  angle_range_reduce_if.slave  bus
);

  localparam int W     = EXP_LEN + MANTISSA_LEN + 1;
  localparam int M     = W - 1;                 // magnitude width {exp, mant}
  localparam int CNT_W = $clog2(MAX_ITER + 1);

  localparam logic [EXP_LEN-1:0] BIAS = {1'b0, {(EXP_LEN-1){1'b1}}};

  // Unsigned {exp, mant} compares order non-negative floats correctly.
  localparam logic [M-1:0] HALF_PI_MAG       = {BIAS, PI_MANTISSA};
  localparam logic [M-1:0] PI_MAG            = {BIAS + EXP_LEN'(1), PI_MANTISSA};
  localparam logic [M-1:0] TWO_PI_MAG        = {BIAS + EXP_LEN'(2), PI_MANTISSA};
  localparam logic [M-1:0] THREE_HALF_PI_MAG = {BIAS + EXP_LEN'(2), THREE_PI_2_MANTISSA};

  localparam logic [W-1:0] CANON_NAN =
    {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

  typedef enum logic [2:0] {
    IDLE, REDUCE, WAIT_R, SIGN, WAIT_S, QUAD, WAIT_W, DONE
  } state_t;

  state_t             state;
  logic               sign_q;
  logic               mode_q;
  logic [M-1:0]       mag_q;
  logic [M-1:0]       r_q;
  logic [CNT_W-1:0]   iter_q;

  logic               out_valid_q;
  logic [W-1:0]       out_angle_q;
  logic [1:0]         out_quad_q;
  logic               out_error_q;
  logic [W-1:0]       add_a_q;
  logic [W-1:0]       add_b_q;
  logic               add_start_q;

  logic [EXP_LEN-1:0] mag_exp;
  logic [EXP_LEN-1:0] sub_exp;
  logic [M-1:0]       r_clamped;
  logic [1:0]         quad;

  // Largest pi*2^k not exceeding mag: same exponent as mag when mag's
  // mantissa is at least pi's, otherwise one binade lower.
  assign mag_exp = mag_q[M-1 -: EXP_LEN];
  assign sub_exp = (mag_q[MANTISSA_LEN-1:0] >= PI_MANTISSA) ? mag_exp
                                                            : mag_exp - EXP_LEN'(1);

  // 2pi - tiny can round up to exactly 2pi; fold that back to +0.
  assign r_clamped = (r_q >= TWO_PI_MAG) ? '0 : r_q;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    quad = 2'd3;
    if (r_clamped < HALF_PI_MAG)            quad = 2'd0;
    else if (r_clamped < PI_MAG)            quad = 2'd1;
    else if (r_clamped < THREE_HALF_PI_MAG) quad = 2'd2;
  end

  // Gated with reset so the source sees not-ready while reset is held.
  assign bus.in_ready     = reset && (state == IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_angle    = out_angle_q;
  assign bus.out_quadrant = out_quad_q;
  assign bus.out_error    = out_error_q;
  assign bus.add_a        = add_a_q;
  assign bus.add_b        = add_b_q;
  assign bus.add_start    = add_start_q;

  // NOTE: non-blocking assignments throughout, so every register samples the
  // values from before this edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: datapath registers are reset as well as control, because every
      // output must read 0 during reset and they are driven straight from here.
      state       <= IDLE;
      sign_q      <= 1'b0;
      mode_q      <= 1'b0;
      mag_q       <= '0;
      r_q         <= '0;
      iter_q      <= '0;
      out_valid_q <= 1'b0;
      out_angle_q <= '0;
      out_quad_q  <= 2'd0;
      out_error_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_start_q <= 1'b0;
    end else begin
      add_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q      <= bus.in_angle[W-1];
            mag_q       <= bus.in_angle[M-1:0];
            mode_q      <= bus.in_mode;
            iter_q      <= '0;
            out_error_q <= 1'b0;
            state       <= REDUCE;
          end
        end

        REDUCE: begin
          if (mag_exp == {EXP_LEN{1'b1}}) begin
            out_angle_q <= CANON_NAN;
            out_quad_q  <= 2'd0;
            out_error_q <= 1'b1;
            state       <= DONE;
          end else if (mag_q >= TWO_PI_MAG) begin
            if (iter_q == ITER_LIMIT) begin
              out_angle_q <= {1'b0, mag_q};
              out_quad_q  <= 2'd0;
              out_error_q <= 1'b1;
              state       <= DONE;
            end else begin
              add_a_q     <= {1'b0, mag_q};
              add_b_q     <= {1'b1, sub_exp, PI_MANTISSA};
              add_start_q <= 1'b1;
              iter_q      <= iter_q + CNT_W'(1);
              state       <= WAIT_R;
            end
          end else begin
            state <= SIGN;
          end
        end

        WAIT_R: begin
          if (bus.add_ready) begin
            mag_q <= bus.add_sum[M-1:0];
            state <= REDUCE;
          end
        end

        SIGN: begin
          // Negative angles map to 2pi - |x|; -0 falls through as +0.
          if (sign_q && (mag_q != '0)) begin
            add_a_q     <= {1'b0, TWO_PI_MAG};
            add_b_q     <= {1'b1, mag_q};
            add_start_q <= 1'b1;
            state       <= WAIT_S;
          end else begin
            r_q   <= mag_q;
            state <= QUAD;
          end
        end

        WAIT_S: begin
          if (bus.add_ready) begin
            r_q   <= bus.add_sum[M-1:0];
            state <= QUAD;
          end
        end

        QUAD: begin
          out_quad_q <= quad;
          if (mode_q && (r_clamped >= PI_MAG)) begin
            add_a_q     <= {1'b0, r_clamped};
            add_b_q     <= {1'b1, TWO_PI_MAG};
            add_start_q <= 1'b1;
            state       <= WAIT_W;
          end else begin
            out_angle_q <= {1'b0, r_clamped};
            state       <= DONE;
          end
        end

        WAIT_W: begin
          if (bus.add_ready) begin
            out_angle_q <= bus.add_sum;
            state       <= DONE;
          end
        end

        DONE: begin
          // First DONE cycle lets the result registers settle; out_valid
          // follows one cycle later and then holds until accepted.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_range_reduce.sv
// ---------------------------------------------------------------------------
// tb_angle_range_reduce
//   Drives angle_range_reduce through its interface, emulates the external
//   float adder, and compares results with a table of known vectors and with
//   a real-arithmetic reference model on random angles.
// ---------------------------------------------------------------------------
module tb_angle_range_reduce;

  localparam logic [31:0] PI_F            = 32'h40490FDB;
  localparam logic [31:0] TWO_PI_F        = 32'h40C90FDB;
  localparam logic [31:0] NEG_TWO_PI_F    = 32'hC0C90FDB;
  localparam logic [31:0] HALF_PI_F       = 32'h3FC90FDB;
  localparam logic [31:0] THREE_HALF_PI_F = 32'h4096CBE4;
  localparam int          ADD_LAT         = 3;
  localparam int          RUN_BOUND       = 3000;

  logic clk;
  logic reset;

  angle_range_reduce_if #(.W(32)) bus ();
  angle_range_reduce_if #(.W(32)) bus4 ();

  angle_range_reduce #(.MAX_ITER(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  angle_range_reduce #(.MAX_ITER(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- float helpers (single <-> real) ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    int          e;
    real         v;
    if (f[30:0] == 31'd0) return 0.0;
    e = int'(f[30:23]);
    if (e == 0) begin
      v = real'(f[22:0]) * 1.401298464324817e-45;
      return f[31] ? -v : v;
    end
    d = {f[31], 11'(e - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    logic [30:0] mag;
    int          e;
    d = $realtobits(x);
    e = int'(d[62:52]) - 1023 + 127;
    if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
    mag = {e[7:0], d[51:29]};
    if (d[28] && ((d[27:0] != 28'd0) || d[29])) mag = mag + 31'd1;
    return {d[63], mag};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // ---------------- reference model ----------------
  // Subtract the largest pi*2^k that fits until below 2pi, wrap negatives
  // with 2pi - |x|, classify, then shift to [-pi, pi) in mode 1.
  task automatic ref_model(input logic [31:0] x, input logic mode, input int max_iter,
                           output logic [31:0] r, output logic [1:0] q,
                           output logic err, output int ops);
    logic [31:0] mb;
    real         sub;
    real         v;
    ops = 0; err = 1'b0; q = 2'd0;
    if (x[30:23] == 8'hFF) begin
      r = 32'h7FC00000; err = 1'b1;
      return;
    end
    mb = {1'b0, x[30:0]};
    while (f2r(mb) >= f2r(TWO_PI_F)) begin
      if (ops == max_iter) begin
        r = mb; err = 1'b1;
        return;
      end
      sub = f2r(PI_F);
      while (sub * 2.0 <= f2r(mb)) sub = sub * 2.0;
      mb = fadd(mb, r2f(-sub));
      mb[31] = 1'b0;
      ops++;
    end
    if (x[31] && mb != 32'd0) begin
      mb = fadd(TWO_PI_F, {1'b1, mb[30:0]});
      ops++;
    end
    if (f2r(mb) >= f2r(TWO_PI_F)) mb = 32'd0;
    v = f2r(mb);
    if (v < f2r(HALF_PI_F))            q = 2'd0;
    else if (v < f2r(PI_F))            q = 2'd1;
    else if (v < f2r(THREE_HALF_PI_F)) q = 2'd2;
    else                               q = 2'd3;
    if (mode && v >= f2r(PI_F)) begin
      mb = fadd(mb, NEG_TWO_PI_F);
      ops++;
    end
    r = mb;
  endtask

  // ---------------- adder emulation ----------------
  int          starts = 0;
  int          starts4 = 0;
  int          inject_req = 0;
  int          inject_done = 0;
  int          lat_a = 0;
  int          lat_b = 0;
  logic [31:0] op_a, op_b, op4_a, op4_b;

  always @(negedge clk) begin
    bus.add_ready = 1'b0;
    if (!reset) begin
      lat_a = 0;
    end else if (inject_req != inject_done) begin
      bus.add_sum   = 32'h12345678;
      bus.add_ready = 1'b1;
      inject_done   = inject_req;
    end else if (bus.add_start) begin
      op_a = bus.add_a; op_b = bus.add_b; lat_a = ADD_LAT; starts++;
    end else if (lat_a > 0) begin
      lat_a--;
      if (lat_a == 0) begin
        bus.add_sum   = fadd(op_a, op_b);
        bus.add_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bus4.add_ready = 1'b0;
    if (!reset) begin
      lat_b = 0;
    end else if (bus4.add_start) begin
      op4_a = bus4.add_a; op4_b = bus4.add_b; lat_b = ADD_LAT; starts4++;
    end else if (lat_b > 0) begin
      lat_b--;
      if (lat_b == 0) begin
        bus4.add_sum   = fadd(op4_a, op4_b);
        bus4.add_ready = 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic check_ulp(input string name, input logic [31:0] got, input logic [31:0] exp);
    logic [31:0] d1, d2;
    d1 = got - exp;
    d2 = exp - got;
    n_checks++;
    if (got === exp || (got[31] == exp[31] && (d1 == 32'd1 || d2 == 32'd1))) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (+-1 ulp)", name, got, exp);
  endtask

  task automatic check_real(input string name, input logic [31:0] got, input real exp,
                            input real tol);
    real g;
    g = f2r(got);
    n_checks++;
    if ((g - exp <= tol) && (exp - g <= tol)) n_pass++;
    else $display("FAIL %s: got %f (0x%08h), expected %f +- %g", name, g, got, exp, tol);
  endtask

  task automatic run(input logic [31:0] angle, input logic mode,
                     output logic [31:0] ang, output logic [1:0] quad,
                     output logic err, output int ops, output int lat);
    int waitc;
    int s0;
    waitc = 0;
    while (!bus.in_ready && waitc < 100) begin
      @(posedge clk); #1; waitc++;
    end
    bus.in_valid = 1'b1;
    bus.in_angle = angle;
    bus.in_mode  = mode;
    s0 = starts;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < RUN_BOUND) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("done_%08h", angle), bus.out_valid, 1);
    ang  = bus.out_angle;
    quad = bus.out_quadrant;
    err  = bus.out_error;
    ops  = starts - s0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check($sformatf("idle_after_hs_%08h", angle), {bus.in_ready, bus.out_valid}, 2'b10);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] angle;
    logic        mode;
    bit          approx;
    logic [31:0] exp_bits;
    real         exp_real;
    logic [1:0]  quad;
    logic        err;
    int          ops;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] g_ang, m_ang;
  logic [1:0]  g_q, m_q;
  logic        g_err, m_err;
  int          g_ops, m_ops, g_lat;
  logic [31:0] x, snap;
  logic        stable, rdy_seen;
  int          s0, waitc;

  initial begin
    vecs[0]  = '{32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 0.0,       2'd0, 1'b0, 0};
    vecs[1]  = '{32'h40E00000, 1'b0, 1'b1, 32'h0,        0.716815,  2'd0, 1'b0, 1};
    vecs[2]  = '{32'h40E00000, 1'b1, 1'b1, 32'h0,        0.716815,  2'd0, 1'b0, 1};
    vecs[3]  = '{32'hBF800000, 1'b0, 1'b1, 32'h0,        5.283185,  2'd3, 1'b0, 1};
    vecs[4]  = '{32'hBF800000, 1'b1, 1'b0, 32'hBF800000, 0.0,       2'd3, 1'b0, 2};
    vecs[5]  = '{32'h42C80000, 1'b1, 1'b1, 32'h0,        -0.530965, 2'd3, 1'b0, 5};
    vecs[6]  = '{32'h7F800000, 1'b0, 1'b0, 32'h7FC00000, 0.0,       2'd0, 1'b1, 0};
    vecs[7]  = '{32'hFF800000, 1'b1, 1'b0, 32'h7FC00000, 0.0,       2'd0, 1'b1, 0};
    vecs[8]  = '{32'h80000000, 1'b0, 1'b0, 32'h00000000, 0.0,       2'd0, 1'b0, 0};
    vecs[9]  = '{32'h00000001, 1'b0, 1'b0, 32'h00000001, 0.0,       2'd0, 1'b0, 0};
    vecs[10] = '{32'h40C90FDB, 1'b0, 1'b0, 32'h00000000, 0.0,       2'd0, 1'b0, 1};
    vecs[11] = '{32'h40490FDB, 1'b1, 1'b0, 32'hC0490FDB, 0.0,       2'd2, 1'b0, 1};
    vecs[12] = '{32'h3FC90FDA, 1'b0, 1'b0, 32'h3FC90FDA, 0.0,       2'd0, 1'b0, 0};
    vecs[13] = '{32'h3FC90FDB, 1'b0, 1'b0, 32'h3FC90FDB, 0.0,       2'd1, 1'b0, 0};
    vecs[14] = '{32'h4096CBE4, 1'b0, 1'b0, 32'h4096CBE4, 0.0,       2'd3, 1'b0, 0};

    reset = 1'b0;
    bus.in_valid = 1'b0;  bus.in_angle = '0;  bus.in_mode = 1'b0;  bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_angle = '0; bus4.in_mode = 1'b0; bus4.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.in_ready, bus.out_valid, bus.out_angle, bus.out_quadrant,
                            bus.out_error, bus.add_start}, '0);
    check("reset_add_ops", {bus.add_a, bus.add_b}, '0);
    reset = 1'b1;
    #1;
    check("ready_after_reset", bus.in_ready, 1);

    // Table vectors
    for (int i = 0; i < 15; i++) begin
      run(vecs[i].angle, vecs[i].mode, g_ang, g_q, g_err, g_ops, g_lat);
      if (vecs[i].approx)
        check_real($sformatf("vec%0d_angle", i), g_ang, vecs[i].exp_real, 1.0e-4);
      else
        check_ulp($sformatf("vec%0d_angle", i), g_ang, vecs[i].exp_bits);
      if (!vecs[i].err) check($sformatf("vec%0d_quad", i), g_q, vecs[i].quad);
      check($sformatf("vec%0d_err", i), g_err, vecs[i].err);
      check($sformatf("vec%0d_ops", i), g_ops, vecs[i].ops);
      if (i == 0) check("latency_in_range", g_lat, 4);
    end

    // Random angles against the reference model
    for (int i = 0; i < 40; i++) begin
      x = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      if (i % 10 == 4) x[30:23] = 8'd0;
      if (i % 10 == 9) x[30:23] = 8'hFF;
      run(x, 1'($urandom_range(0, 1)), g_ang, g_q, g_err, g_ops, g_lat);
      ref_model(x, bus.in_mode, 16, m_ang, m_q, m_err, m_ops);
      check_ulp($sformatf("rnd%0d_angle_%08h", i, x), g_ang, m_ang);
      if (!m_err) check($sformatf("rnd%0d_quad", i), g_q, m_q);
      check($sformatf("rnd%0d_err", i), g_err, m_err);
      check($sformatf("rnd%0d_ops", i), g_ops, m_ops);
    end

    // +Inf then hold the result with out_ready low while in_valid stays high
    bus.in_valid = 1'b1; bus.in_angle = 32'h7F800000; bus.in_mode = 1'b0;
    s0 = starts;
    @(posedge clk); #1;
    bus.in_angle = 32'h3F800000;
    waitc = 0;
    while (!bus.out_valid && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    check("hold_valid", bus.out_valid, 1);
    check("hold_inf_angle", bus.out_angle, 32'h7FC00000);
    check("hold_inf_err", bus.out_error, 1);
    snap = bus.out_angle;
    stable = 1'b1; rdy_seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_angle !== snap || !bus.out_valid || !bus.out_error) stable = 1'b0;
      if (bus.in_ready) rdy_seen = 1'b1;
    end
    check("hold_stable", stable, 1);
    check("hold_in_ready_low", rdy_seen, 0);
    check("hold_no_add_start", starts - s0, 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("hold_release", {bus.in_ready, bus.out_valid}, 2'b10);
    @(posedge clk); #1;
    check("hold_no_second_accept", bus.in_ready, 1);

    // Reset while waiting on the adder, then a stale add_ready
    bus.in_valid = 1'b1; bus.in_angle = 32'h42C80000; bus.in_mode = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    waitc = 0;
    while (!bus.add_start && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    check("wait_r_reached", bus.add_start, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midop_reset_outputs", {bus.in_ready, bus.out_valid, bus.out_angle, bus.out_quadrant,
                                  bus.out_error, bus.add_start}, '0);
    check("midop_reset_add_ops", {bus.add_a, bus.add_b}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midop_ready_after_release", bus.in_ready, 1);
    inject_req++;
    s0 = starts;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!bus.in_ready || bus.out_valid || bus.add_start) stable = 1'b0;
    end
    check("late_ready_ignored", stable, 1);
    check("late_ready_delivered", inject_done, inject_req);
    run(32'h3F800000, 1'b0, g_ang, g_q, g_err, g_ops, g_lat);
    check("post_reset_angle", g_ang, 32'h3F800000);
    check("post_reset_latency", g_lat, 4);
    check("post_reset_ops", g_ops, 0);

    // Iteration limit on the MAX_ITER=4 instance with 1.0e6
    check("lim_ready", bus4.in_ready, 1);
    bus4.in_valid = 1'b1; bus4.in_angle = 32'h49742400; bus4.in_mode = 1'b0;
    s0 = starts4;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    waitc = 0;
    while (!bus4.out_valid && waitc < 500) begin
      @(posedge clk); #1; waitc++;
    end
    ref_model(32'h49742400, 1'b0, 4, m_ang, m_q, m_err, m_ops);
    check("lim_valid", bus4.out_valid, 1);
    check("lim_err", bus4.out_error, 1);
    check("lim_starts", starts4 - s0, 4);
    check_ulp("lim_angle", bus4.out_angle, m_ang);
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    check("lim_idle", bus4.in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/angle_range_reduce.md
# angle_range_reduce

Parametrised successor to the team's angle normaliser. It accepts one IEEE-754-style float angle in radians over a valid/ready handshake and reduces it to [0, 2π) (mode 0) or [-π, π) (mode 1), together with a quadrant code and an error flag. All add/subtract work goes to a shared external float adder through a start/ready port pair. The block sits between the angle source and the CORDIC/trig datapath.

## Interface
- EXP_LEN, 8, exponent bits
- MANTISSA_LEN, 23, mantissa bits
- PI_MANTISSA, 23'h490FDB, mantissa of π (π exponent field = BIAS+1)
- THREE_PI_2_MANTISSA, 23'h16CBE4, mantissa of 3π/2 (exponent field BIAS+2)
- MAX_ITER, 16, maximum subtraction passes before abort
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  input angle valid
- in_ready  out  1  block idle and able to accept
- in_angle  in  W=EXP_LEN+MANTISSA_LEN+1  input angle
- in_mode  in  1  0: [0,2π), 1: [-π,π); sampled at accept
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- out_angle  out  W  reduced angle
- out_quadrant  out  2  quadrant of the [0,2π) value
- out_error  out  1  NaN/Inf input or MAX_ITER exceeded
- add_a, add_b  out  W  adder operands
- add_start  out  1  one-cycle adder start pulse
- add_sum  in  W  adder result
- add_ready  in  1  add_sum valid this cycle

## Operation
- Derived values: BIAS = 2^(EXP_LEN-1)-1. π/2 = {0,BIAS,PI_M}, π = {0,BIAS+1,PI_M}, 2π = {0,BIAS+2,PI_M}, 3π/2 = {0,BIAS+2,3PI2_M}.
- All magnitude compares are unsigned compares on {exp,mantissa}.
- Accept happens on in_valid&&in_ready. On accept, register sign, magnitude, mode, and clear the iteration counter.
- States:
  - IDLE: in_ready=1. On accept, go to REDUCE.
  - REDUCE:
    - If exp is all ones: out_angle=canonical NaN {0,all-ones exp,1000…0}, error=1, go to DONE.
    - Else if mag ≥ 2π: set e = mag.exp if mag.mant ≥ PI_M, else mag.exp-1. Drive add_a=mag, add_b={1,e,PI_M}, pulse add_start, increment the counter, go to WAIT_R.
    - Else go to SIGN.
    - If the counter already equals MAX_ITER when a subtraction is needed: error=1, output the current magnitude, go to DONE.
  - WAIT_R: on add_ready, take mag=add_sum with the sign bit cleared, go to REDUCE.
  - SIGN:
    - If sign=1 and mag≠0: add_a=2π, add_b={1,mag}, pulse start, go to WAIT_S.
    - Else r=mag, go to QUAD.
  - WAIT_S: on add_ready, r=add_sum, go to QUAD.
  - QUAD:
    - If r ≥ 2π (a rounding artefact), force r=+0.
    - Quadrant: 0 if r<π/2, 1 if r<π, 2 if r<3π/2, else 3.
    - If mode=1 and r ≥ π: add_a=r, add_b={1,2π}, pulse start, go to WAIT_W.
    - Else out_angle=r, go to DONE.
  - WAIT_W: on add_ready, out_angle=add_sum, go to DONE.
  - DONE: out_valid=1 and outputs stable. On out_ready, go to IDLE.
- Denormal and zero inputs take the < 2π path unchanged. -0 yields +0, quadrant 0.

## Timing
- Reset values: every output is 0 (in_ready=0 while reset is asserted). State goes to IDLE, and in_ready is 1 in the first cycle after deassertion.
- add_start is high for exactly one cycle per operation. add_a and add_b stay stable until add_ready.
- add_ready is ignored outside the WAIT states. add_ready in the same cycle as add_start is not expected.
- Latency for an in-range positive input: out_valid rises on the 4th rising edge after the accepting edge. Each adder operation adds 2 cycles plus the adder latency.
- While busy, in_valid is ignored (in_ready=0). The output is held indefinitely while out_ready=0.
- in_ready reasserts the cycle after the out_valid&&out_ready handshake, so there is no same-cycle turnaround.
- Reset mid-operation clears everything immediately. A late add_ready after reset is ignored.

## Test plan
- 1.0 (0x3F800000), mode 0: out 0x3F800000, quadrant 0, error 0, no add_start, out_valid 4 cycles after accept.
- 7.0 (0x40E00000), mode 0: one add_start, out ≈0.716815 (±1 ulp of the bench float model), quadrant 0. The same input with mode 1 gives the same value.
- -1.0 (0xBF800000):
  - mode 0: out ≈5.283185, quadrant 3, one adder op.
  - mode 1: out ≈-1.0 (0xBF800000 ±1 ulp), quadrant 3, two adder ops.
- Range and iteration limit:
  - 100.0, mode 1: out ≈-0.530965, quadrant 3, at most MAX_ITER+2 adder ops.
  - 1.0e6 with MAX_ITER=4: error=1 after exactly 4 reduction starts.
- +Inf (0x7F800000): out 0x7FC00000, error 1, no add_start.
  - Hold out_ready=0 for 10 cycles with in_valid high: output is stable, in_ready stays 0, and no second accept occurs.
- Assert reset during WAIT_R, then pulse add_ready after release: all outputs are 0 and in_ready=1 after release. The late add_ready causes no state change, and the next input (1.0) processes normally.
